// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// The sub signal exists only when ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;

  modport slave (
    input  in_valid, A, B, Ci, out_ready,
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, S, Co, V
  );

  modport master (
    output in_valid, A, B, Ci, out_ready,
`ifdef ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, S, Co, V
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: CHUNK bits per RUN cycle with a registered inter-chunk carry.
// Define ADDER_SUB_EN to add the sub port (A - B via ~B and forced carry-in).
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic             r_v;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_lat;
  logic             w_cin_lat;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic             w_msb_cin;

`ifdef ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_b_lat   = w_sub ? ~bus.B : bus.B;
  assign w_cin_lat = w_sub ? 1'b1 : bus.Ci;
  assign w_accept  = (r_state == IDLE) && bus.in_valid;

  assign w_a = r_op_a[r_cnt*CHUNK +: CHUNK];
  assign w_b = r_op_b[r_cnt*CHUNK +: CHUNK];
  assign {w_c, w_s} = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the chunk MSB recovered from the MSB sum bit (valid for any CHUNK).
  assign w_msb_cin = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_s[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)   w_state_next = RUN;
      RUN:     if (r_cnt == LAST)  w_state_next = DONE;
      DONE:    if (bus.out_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_v     <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op_a  <= bus.A;
      r_op_b  <= w_b_lat;
      r_carry <= w_cin_lat;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_s[r_cnt*CHUNK +: CHUNK] <= w_s;
      r_carry <= w_c;
      if (r_cnt == LAST) begin
        r_co <= w_c;
        r_v  <= w_msb_cin ^ w_c;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.S         = r_s;
  assign bus.Co        = r_co;
  assign bus.V         = r_v;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: randomized and directed operations
// checked against an integer-arithmetic reference model.
module tb_chunked_serial_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             v;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_sub = 1'b0;
  logic prev_ov = 1'b0;
  bit   rand_bp = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  res_t exp_q[$];
  int   lat_q[$];

  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(WIDTH)) bus ();

`ifdef ADDER_SUB_EN
  assign bus.sub = drv_sub;
`endif

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain integer arithmetic on the full operands.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sub);
    res_t   r;
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[WIDTH-1]) ? ua - (longint'(1) << WIDTH) : ua;
    sb = (b[WIDTH-1]) ? ub - (longint'(1) << WIDTH) : ub;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      r.co = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(ci);
      sres = sa + sb + longint'(ci);
      r.co = (ures >= (longint'(1) << WIDTH));
    end
    r.s = WIDTH'(ures);
    r.v = (sres >= (longint'(1) << (WIDTH-1))) || (sres < -(longint'(1) << (WIDTH-1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Input-side observer: push expected result at each accept edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.A, bus.B, bus.Ci, drv_sub));
      lat_q.push_back(cyc + 1);
      $display("IN  A=%h B=%h Ci=%0d sub=%0d cycle=%0d", bus.A, bus.B, bus.Ci, drv_sub, cyc + 1);
    end
  end

  // Output-side monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    res_t e;
    #1;
    if (rst_n) begin
      chk("ready_valid_exclusive", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else chk("latency", cyc - lat_q.pop_front(), N);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_without_op", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("OUT S=%h Co=%0d V=%0d expected S=%h Co=%0d V=%0d", bus.S, bus.Co, bus.V, e.s, e.co, e.v);
          chk("result", {15'd0, bus.S, bus.Co, bus.V}, {15'd0, e.s, e.co, e.v});
        end
      end
    end
    prev_ov <= bus.out_valid;
  end

  always @(negedge clk) begin
    if (rand_bp) bus.out_ready <= ($urandom_range(0, 1) == 1);
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic s);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("send_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.A = a;
    bus.B = b;
    bus.Ci = ci;
    drv_sub = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   t;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Ci = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_S_Co_V", {15'd0, bus.S, bus.Co, bus.V}, 32'd0);
    rst_n = 1'b1;

    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
`ifdef ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
`endif
    wait_idle();

    // Backpressure: result held, new operands ignored, no early accept.
    bus.out_ready = 1'b0;
    send(16'h1234, 16'hF00D, 1'b1, 1'b0);
    e = model(16'h1234, 16'hF00D, 1'b1, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_result", {15'd0, bus.S, bus.Co, bus.V}, {15'd0, e.s, e.co, e.v});
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      bus.A = 16'hFFFF;
      bus.B = 16'hFFFF;
      bus.in_valid = (i == 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("bp_in_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_out_valid_after_hs", {31'd0, bus.out_valid}, 32'd0);

    // Reset while cnt=2 in RUN, then a clean operation.
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrun_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrun_rst_S_Co_V", {15'd0, bus.S, bus.Co, bus.V}, 32'd0);
    rst_n = 1'b1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_idle();

    // Random operations with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
`ifdef ADDER_SUB_EN
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`else
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
`endif
    end
    wait_idle();
    rand_bp = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
